// File: rtl/cla_addsub_pipe_if.sv
// Stream bundle for the pipelined CLA adder/subtractor: upstream operation
// handshake, downstream result handshake, operands, result and flags.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic             i_sub;
    logic             i_carry;
    logic [WIDTH-1:0] i_data_a;
    logic [WIDTH-1:0] i_data_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_ovf;
    logic             o_zero;

    // The adder side of the bundle.
    modport slave (
        input  i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
        output o_ready, o_valid, o_sum, o_carry, o_ovf, o_zero
    );

    // The environment side: issues operations and consumes results.
    modport master (
        output i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
        input  o_ready, o_valid, o_sum, o_carry, o_ovf, o_zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit operation is cut into STAGES segments of WIDTH/STAGES bits.
// Each stage resolves one segment with 4-bit CLA groups and a flat group
// lookahead from the registered segment carry, then hands the operands, the
// partial sum and the carry to the next stage. The last stage register is the
// output register; flags are formed there from the complete sum.
// The whole pipe advances together (global stall) whenever the output slot is
// empty or being drained, which also defines o_ready.
// WIDTH must be a multiple of 4*STAGES. i_rst is expected to be released
// synchronously to i_clk by the reset distribution upstream.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic               i_clk,
    input logic               i_rst,
    cla_addsub_pipe_if.slave  bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / 4;

    logic             advance;
    logic             vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign advance     = ~vld_q | bus.i_ready;
    assign bus.o_ready = advance;
    assign bus.o_valid = vld_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = cout_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_zero  = zero_q;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : stg
            logic [WIDTH-1:0] in_a;
            logic [WIDTH-1:0] in_b;
            logic [WIDTH-1:0] in_s;
            logic             in_c;
            logic             in_v;
            logic [SEG-1:0]   sa;
            logic [SEG-1:0]   sb;
            logic [SEG-1:0]   bp;
            logic [SEG-1:0]   bg;
            logic [SEG-1:0]   ss;
            logic [NGRP-1:0]  gp;
            logic [NGRP-1:0]  gg;
            logic [NGRP:0]    gc;
            logic [3:0]       cq;
            logic             pp;
            logic [WIDTH-1:0] nxt_s;

            if (k == 0) begin : src
                // Subtract is A + ~B + 1; the external carry only matters for add.
                assign in_a = bus.i_data_a;
                assign in_b = bus.i_sub ? ~bus.i_data_b : bus.i_data_b;
                assign in_c = bus.i_sub | bus.i_carry;
                assign in_s = '0;
                assign in_v = bus.i_valid;
            end else begin : src
                assign in_a = stg[k-1].fwd.a_q;
                assign in_b = stg[k-1].fwd.b_q;
                assign in_c = stg[k-1].fwd.c_q;
                assign in_s = stg[k-1].fwd.s_q;
                assign in_v = stg[k-1].fwd.v_q;
            end

            assign sa = in_a[k*SEG +: SEG];
            assign sb = in_b[k*SEG +: SEG];

            // Segment CLA: group P/G, flat group carries from the segment carry-in, bit sums.
            always_comb begin : seg_cla
                bp = sa ^ sb;
                bg = sa & sb;
                gp = '0;
                gg = '0;
                gc = '0;
                ss = '0;
                cq = '0;
                pp = 1'b1;
                for (int j = 0; j < NGRP; j++) begin
                    gp[j] = &bp[j*4 +: 4];
                    gg[j] = bg[j*4+3]
                          | (bp[j*4+3] & bg[j*4+2])
                          | (bp[j*4+3] & bp[j*4+2] & bg[j*4+1])
                          | (bp[j*4+3] & bp[j*4+2] & bp[j*4+1] & bg[j*4]);
                end
                // Each group carry is a sum of products straight from in_c; no group-to-group ripple.
                for (int j = 0; j <= NGRP; j++) begin
                    pp = 1'b1;
                    for (int i = j - 1; i >= 0; i--) begin
                        gc[j] = gc[j] | (pp & gg[i]);
                        pp    = pp & gp[i];
                    end
                    gc[j] = gc[j] | (pp & in_c);
                end
                for (int j = 0; j < NGRP; j++) begin
                    cq[0] = gc[j];
                    cq[1] = bg[j*4] | (bp[j*4] & gc[j]);
                    cq[2] = bg[j*4+1] | (bp[j*4+1] & bg[j*4])
                          | (bp[j*4+1] & bp[j*4] & gc[j]);
                    cq[3] = bg[j*4+2] | (bp[j*4+2] & bg[j*4+1])
                          | (bp[j*4+2] & bp[j*4+1] & bg[j*4])
                          | (bp[j*4+2] & bp[j*4+1] & bp[j*4] & gc[j]);
                    ss[j*4 +: 4] = bp[j*4 +: 4] ^ cq;
                end
            end

            // Drop this stage's segment into the partial sum travelling down the pipe.
            always_comb begin : merge
                nxt_s = in_s;
                nxt_s[k*SEG +: SEG] = ss;
            end

            if (k < STAGES - 1) begin : fwd
                logic             v_q;
                logic             c_q;
                logic [WIDTH-1:0] a_q;
                logic [WIDTH-1:0] b_q;
                logic [WIDTH-1:0] s_q;

                // Inter-stage register: operands, partial sum and segment carry move in lockstep.
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        v_q <= 1'b0;
                        c_q <= 1'b0;
                        a_q <= '0;
                        b_q <= '0;
                        s_q <= '0;
                    end else if (advance) begin
                        v_q <= in_v;
                        c_q <= gc[NGRP];
                        a_q <= in_a;
                        b_q <= in_b;
                        s_q <= nxt_s;
                    end
                end
            end
        end
    endgenerate

    logic             fin_a_msb;
    logic             fin_b_msb;
    logic [WIDTH-1:0] fin_sum;

    assign fin_a_msb = stg[STAGES-1].in_a[WIDTH-1];
    assign fin_b_msb = stg[STAGES-1].in_b[WIDTH-1];
    assign fin_sum   = stg[STAGES-1].nxt_s;

    // Output register: result and flags are captured together, so a stalled result stays frozen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q  <= stg[STAGES-1].in_v;
            sum_q  <= fin_sum;
            cout_q <= stg[STAGES-1].gc[NGRP];
            ovf_q  <= (fin_a_msb == fin_b_msb) & (fin_sum[WIDTH-1] != fin_a_msb);
            zero_q <= ~|fin_sum;
        end
    end

    // Operand bits of segments already summed reach the last stage but feed nothing there.
    logic unused_consumed;
    generate
        if (STAGES > 1) begin : g_sink
            assign unused_consumed = ^{stg[STAGES-1].in_a[(STAGES-1)*SEG-1:0],
                                       stg[STAGES-1].in_b[(STAGES-1)*SEG-1:0]};
        end else begin : g_sink
            assign unused_consumed = 1'b0;
        end
    endgenerate
endmodule
